// File: rtl/dma_ctrl_pkg.sv
// Shared constants and state encoding for the resize-path DMA read/write controllers.
package dma_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    BURST,
    NEXT
  } dma_state_e;

  localparam logic [15:0] BURST_LEN       = 16'd418;
  localparam int          LINES_PER_FRAME = 258;
  localparam logic [31:0] ADDR_BASE0      = 32'h3500_0000;
  localparam logic [31:0] ADDR_BASE1      = 32'h3600_0000;
  localparam int          FIFO_DEPTH      = 512;

  localparam logic [31:0] ADDR_INC     = {16'd0, BURST_LEN} << 3;
  // Highest FIFO occupancy that still leaves room for one whole burst.
  localparam logic [8:0]  SPACE_THRESH = 9'(FIFO_DEPTH - int'(BURST_LEN));
  localparam logic [8:0]  LAST_LINE    = 9'(LINES_PER_FRAME - 1);

endpackage

// File: rtl/dma_rd_addr_gen.sv
// Burst line counter and byte offset for the DMA read controller, with last-line flag.
module dma_rd_addr_gen
  import dma_ctrl_pkg::*;
(
  input  logic        ui_clk,
  input  logic        rst,
  input  logic        i_advance,
  input  logic        i_clear,
  output logic [31:0] o_addr_off,
  output logic        o_last
);

  logic [8:0]  r_line_cnt;
  logic [31:0] r_addr_off;

  always_ff @(posedge ui_clk) begin
    if (rst || i_clear) begin
      r_line_cnt <= '0;
      r_addr_off <= '0;
    end else if (i_advance) begin
      r_line_cnt <= r_line_cnt + 9'd1;
      r_addr_off <= r_addr_off + ADDR_INC;
    end
  end

  assign o_addr_off = r_addr_off;
  assign o_last     = (r_line_cnt == LAST_LINE);

endmodule

// File: rtl/dma_rd_control.sv
// Fetches one frame from DDR in fixed bursts into a downstream FIFO, ping-pong buffer select.
// Optional beat-count error checking is built when DMA_RD_BEAT_CHECK_EN is defined.
module dma_rd_control
  import dma_ctrl_pkg::*;
(
  input  logic        ui_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        buf_sel,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  input  logic [8:0]  fifo_count,
  output logic        fifo_wr_en,
  output logic [63:0] fifo_wdata,
  output logic [31:0] dma_raddr,
  output logic        dma_rareq,
  input  logic        dma_rbusy,
  output logic [15:0] dma_rsize,
  input  logic [63:0] dma_rdata,
  input  logic        dma_rvalid,
  output logic        dma_rready
);

  dma_state_e  r_state;
  dma_state_e  w_state_nxt;
  logic        r_rareq;
  logic        r_busy;
  logic        r_buf_sel_q;
  logic        w_last;
  logic        w_advance;
  logic        w_clear;
  logic [31:0] w_addr_off;
  logic        w_rready;
  logic        w_wr_en;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (start) w_state_nxt = WAIT_SPACE;
      WAIT_SPACE: if ((fifo_count <= SPACE_THRESH) && !dma_rbusy) w_state_nxt = REQ;
      REQ:        if (r_rareq && dma_rbusy) w_state_nxt = BURST;
      BURST:      if (!dma_rbusy) w_state_nxt = NEXT;
      NEXT:       w_state_nxt = w_last ? IDLE : WAIT_SPACE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rareq <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rareq <= (w_state_nxt == REQ);
      if ((r_state == IDLE) && start)
        r_busy <= 1'b1;
      else if ((r_state == NEXT) && w_last)
        r_busy <= 1'b0;
    end
  end

  // NOTE: r_buf_sel_q needs no reset; it is always loaded on start before any address is used.
  always_ff @(posedge ui_clk) begin
    if ((r_state == IDLE) && start)
      r_buf_sel_q <= buf_sel;
  end

  assign w_advance = (r_state == NEXT) && !w_last;
  assign w_clear   = (r_state == NEXT) && w_last;

  dma_rd_addr_gen u_addr_gen (
    .ui_clk     (ui_clk),
    .rst        (rst),
    .i_advance  (w_advance),
    .i_clear    (w_clear),
    .o_addr_off (w_addr_off),
    .o_last     (w_last)
  );

  assign w_rready = (r_state == REQ) || (r_state == BURST);
  assign w_wr_en  = dma_rvalid && w_rready;

  assign dma_rready = w_rready;
  assign fifo_wr_en = w_wr_en;
  assign fifo_wdata = dma_rdata;
  assign dma_raddr  = (r_buf_sel_q ? ADDR_BASE1 : ADDR_BASE0) + w_addr_off;
  assign dma_rsize  = BURST_LEN;
  assign dma_rareq  = r_rareq;
  assign busy       = r_busy;
  // Asserted while in NEXT so a start in the same cycle is not yet accepted.
  assign frame_done = (r_state == NEXT) && w_last;

`ifdef DMA_RD_BEAT_CHECK_EN
  logic [15:0] r_beat_cnt;
  logic [15:0] w_beat_cnt_nxt;
  logic        r_err;

  assign w_beat_cnt_nxt = r_beat_cnt + {15'd0, w_wr_en};

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == WAIT_SPACE) && (w_state_nxt == REQ))
        r_beat_cnt <= '0;
      else
        r_beat_cnt <= w_beat_cnt_nxt;
      // The closing cycle's own beat is included in the comparison.
      if ((r_state == BURST) && (w_state_nxt == NEXT) && (w_beat_cnt_nxt != BURST_LEN))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dma_rd_control.sv
// Self-checking bench for dma_rd_control: frame-level model plus directed burst scenarios.
module tb_dma_rd_control;
  import dma_ctrl_pkg::*;

  logic        ui_clk;
  logic        rst;
  logic        start;
  logic        buf_sel;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [8:0]  fifo_count;
  logic        fifo_wr_en;
  logic [63:0] fifo_wdata;
  logic [31:0] dma_raddr;
  logic        dma_rareq;
  logic        dma_rbusy;
  logic [15:0] dma_rsize;
  logic [63:0] dma_rdata;
  logic        dma_rvalid;
  logic        dma_rready;

  dma_rd_control dut (
    .ui_clk     (ui_clk),
    .rst        (rst),
    .start      (start),
    .buf_sel    (buf_sel),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .fifo_count (fifo_count),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .dma_raddr  (dma_raddr),
    .dma_rareq  (dma_rareq),
    .dma_rbusy  (dma_rbusy),
    .dma_rsize  (dma_rsize),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_rready (dma_rready)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

`ifdef DMA_RD_BEAT_CHECK_EN
  localparam bit BEAT_CHK = 1'b1;
`else
  localparam bit BEAT_CHK = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase of the current burst, which line, which buffer.
  typedef enum {M_IDLE, M_SPACE, M_ASK, M_DATA, M_WRAP} mph_e;
  mph_e m_ph    = M_IDLE;
  bit   m_en    = 1'b0;
  bit   m_busy  = 1'b0;
  bit   m_err   = 1'b0;
  bit   m_sel   = 1'b0;
  int   m_line  = 0;
  int   m_beats = 0;
  int   wr_total = 0;
  int   fd_count = 0;

  always @(negedge ui_clk) begin
    if (m_en) begin
      logic        exp_rdy;
      logic        exp_wr;
      logic        exp_fd;
      logic [31:0] exp_addr;
      exp_rdy  = (m_ph == M_ASK) || (m_ph == M_DATA);
      exp_wr   = exp_rdy && dma_rvalid;
      exp_fd   = (m_ph == M_WRAP) && (m_line == LINES_PER_FRAME - 1);
      exp_addr = (m_sel ? 32'h3600_0000 : 32'h3500_0000) + 32'(m_line) * 32'(BURST_LEN) * 32'd8;
      check("rareq",      dma_rareq,  m_ph == M_ASK);
      check("rready",     dma_rready, exp_rdy);
      check("fifo_wr_en", fifo_wr_en, exp_wr);
      check("busy",       busy,       m_busy);
      check("frame_done", frame_done, exp_fd);
      check("err",        err,        m_err);
      check("rsize",      dma_rsize,  16'd418);
      if (exp_wr)         check("fifo_wdata", fifo_wdata, dma_rdata);
      if (m_ph == M_ASK)  check("raddr", dma_raddr, exp_addr);
      if (fifo_wr_en) wr_total++;
      if (frame_done) fd_count++;

      if (rst) begin
        m_ph = M_IDLE; m_busy = 1'b0; m_err = 1'b0; m_line = 0;
      end else begin
        if (exp_wr) m_beats++;
        case (m_ph)
          M_IDLE:  if (start) begin m_sel = buf_sel; m_busy = 1'b1; m_ph = M_SPACE; end
          M_SPACE: if (fifo_count <= 9'd94 && !dma_rbusy) begin m_ph = M_ASK; m_beats = 0; end
          M_ASK:   if (dma_rbusy) m_ph = M_DATA;
          M_DATA:  if (!dma_rbusy) begin
                     if (BEAT_CHK && m_beats != 418) m_err = 1'b1;
                     m_ph = M_WRAP;
                   end
          M_WRAP:  if (m_line == LINES_PER_FRAME - 1) begin
                     m_line = 0; m_busy = 1'b0; m_ph = M_IDLE;
                   end else begin
                     m_line++; m_ph = M_SPACE;
                   end
          default: m_ph = M_IDLE;
        endcase
      end
    end
  end

  // DMA engine model: answers one request with nbeats beats after delay cycles.
  task automatic respond(input int nbeats, input int delay, input int rst_at,
                         output logic [31:0] addr, output int req_hi);
    int n;
    n = 0; req_hi = 0; addr = '0;
    while (!dma_rareq && n < 1000) begin
      @(posedge ui_clk); #1; n++;
    end
    if (!dma_rareq) begin
      check("req_timeout", dma_rareq, 1'b1);
      return;
    end
    addr   = dma_raddr;
    req_hi = 1;
    for (int k = 0; k < delay; k++) begin
      @(posedge ui_clk); #1;
      if (dma_rareq) req_hi++;
    end
    dma_rbusy = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      dma_rvalid = 1'b1;
      dma_rdata  = {$urandom, $urandom};
      if (i == rst_at) rst = 1'b1;
      @(posedge ui_clk); #1;
      if (i == rst_at) begin
        rst = 1'b0;
        return;
      end
    end
    dma_rvalid = 1'b0;
    dma_rbusy  = 1'b0;
    @(posedge ui_clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge ui_clk); #1;
    start = 1'b0;
  endtask

  logic [31:0] a;
  int          h;

  initial begin
    rst = 1'b1; start = 1'b0; buf_sel = 1'b0; fifo_count = '0;
    dma_rbusy = 1'b0; dma_rdata = '0; dma_rvalid = 1'b0;
    @(posedge ui_clk); #1;
    m_en = 1'b1;
    @(posedge ui_clk); #1;
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_rareq", dma_rareq, 1'b0);
    check("rst_err", err, 1'b0);

    // Stray beats while idle must not reach the FIFO.
    dma_rvalid = 1'b1;
    repeat (3) begin @(posedge ui_clk); #1; end
    check("idle_wr_en", fifo_wr_en, 1'b0);
    dma_rvalid = 1'b0;

    // Frame A: buffer 0, full-length bursts first, one short burst on line 3.
    wr_total = 0; fd_count = 0;
    buf_sel = 1'b0; fifo_count = 9'd0;
    pulse_start();
    check("a_busy_up", busy, 1'b1);
    respond(418, 0, -1, a, h);  check("a_addr0", a, 32'h3500_0000);
    respond(418, 0, -1, a, h);  check("a_addr1", a, 32'h3500_0D10);
    respond(418, 0, -1, a, h);
    check("a_wr_3lines", 32'(wr_total), 32'd1254);
    check("a_err_full", err, 1'b0);
    respond(417, 0, -1, a, h);
    check("a_err_short", err, BEAT_CHK);
    for (int l = 4; l < LINES_PER_FRAME - 1; l++) respond(2, 0, -1, a, h);
    respond(2, 0, -1, a, h);
    check("a_addr_last", a, 32'h350D_1D10);
    check("a_frame_done", frame_done, 1'b1);
    start = 1'b1;  // coincident with frame_done: ignored
    @(posedge ui_clk); #1;
    start = 1'b0;
    check("a_busy_down", busy, 1'b0);
    @(posedge ui_clk); #1;
    check("a_start_ignored", busy, 1'b0);
    check("a_fd_count", 32'(fd_count), 32'd1);
    check("a_wr_total", 32'(wr_total), 32'd2179);

    // Frame B: buffer 1, buf_sel toggled mid-frame, FIFO threshold and late rbusy.
    buf_sel = 1'b1; fifo_count = 9'd95;
    pulse_start();
    buf_sel = 1'b0;
    repeat (10) begin @(posedge ui_clk); #1; end
    check("b_hold_95", dma_rareq, 1'b0);
    fifo_count = 9'd94;
    @(posedge ui_clk); #1;
    check("b_req_94", dma_rareq, 1'b1);
    respond(418, 0, -1, a, h);  check("b_addr0", a, 32'h3600_0000);
    fifo_count = 9'd0;
    respond(2, 4, -1, a, h);
    check("b_addr1", a, 32'h3600_0D10);
    check("b_req_hi_cycles", 32'(h), 32'd5);
    for (int l = 2; l < LINES_PER_FRAME; l++) begin
      buf_sel = l[0];
      respond(2, 0, -1, a, h);
    end
    check("b_addr_last", a, 32'h360D_1D10);
    repeat (2) begin @(posedge ui_clk); #1; end
    check("b_busy_down", busy, 1'b0);

    // Frame C: reset at beat 200 of line 10, then restart from offset 0.
    buf_sel = 1'b0;
    pulse_start();
    for (int l = 0; l < 10; l++) respond(2, 0, -1, a, h);
    respond(418, 0, 200, a, h);
    check("c_addr10", a, 32'h3500_0000 + 32'd10 * 32'h0D10);
    check("c_rst_busy", busy, 1'b0);
    check("c_rst_rareq", dma_rareq, 1'b0);
    check("c_rst_rready", dma_rready, 1'b0);
    check("c_rst_wr_en", fifo_wr_en, 1'b0);
    check("c_rst_err", err, 1'b0);
    repeat (3) begin
      dma_rdata = {$urandom, $urandom};
      @(posedge ui_clk); #1;
    end
    dma_rvalid = 1'b0; dma_rbusy = 1'b0;
    @(posedge ui_clk); #1;
    pulse_start();
    respond(2, 0, -1, a, h);
    check("c_restart_addr", a, 32'h3500_0000);
    repeat (3) begin @(posedge ui_clk); #1; end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
